fsk_demod_param: RTL and testbench

// - Parametrised FSK bit slicer: counts received samples that fall inside an amplitude/frequency

---
 rtl/fsk_pkg.sv | 19 +
 rtl/fsk_demod_param_ticker.sv | 42 ++++
 rtl/fsk_demod_param.sv | 100 ++++++++++
 tb/tb_fsk_demod_param.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fsk_pkg.sv
// Shared constants and helpers for the FSK bit slicer.
// Decision-mode codes, default window bounds, window test.
package fsk_pkg;

  localparam int FSK_MODE_VOTE = 0;
  localparam int FSK_MODE_MAJ  = 1;

  localparam int FSK_LO_TH_DEF = 100;
  localparam int FSK_HI_TH_DEF = 200;

  function automatic logic in_window(
    input int unsigned sample,
    input int unsigned lo,
    input int unsigned hi
  );
    return (sample >= lo) && (sample <= hi);
  endfunction

endpackage

// File: rtl/fsk_demod_param_ticker.sv
// Sample/symbol phase counters for the FSK slicer.
// Ticks are enables for the accumulator, never clocks.
module fsk_sample_ticker #(
  parameter int SYM_LEN  = 256,
  parameter int SAMP_DIV = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_sync,
  output logic o_samp_tick,
  output logic o_sym_end
);

  localparam int DW = (SAMP_DIV > 1) ? $clog2(SAMP_DIV) : 1;
  localparam int SW = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMP_DIV - 1);
  localparam logic [SW-1:0] SYM_LAST = SW'(SYM_LEN - 1);

  logic [DW-1:0] r_div_cnt;
  logic [SW-1:0] r_sym_cnt;
  logic          w_div_last;
  logic          w_sym_last;
  logic          w_run;

  assign w_div_last  = (r_div_cnt == DIV_LAST);
  assign w_sym_last  = (r_sym_cnt == SYM_LAST);
  assign w_run       = i_en && !i_sync;
  assign o_samp_tick = w_run && w_div_last;
  assign o_sym_end   = w_run && w_sym_last;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_sync) begin
      r_div_cnt <= '0;
      r_sym_cnt <= '0;
    end else if (i_en) begin
      r_div_cnt <= w_div_last ? '0 : r_div_cnt + 1'b1;
      r_sym_cnt <= w_sym_last ? '0 : r_sym_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fsk_demod_param.sv
// FSK bit slicer: counts in-window samples per symbol and
// decides one bit per symbol with a valid strobe.
module fsk_demod_param
  import fsk_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int SYM_LEN  = 256,
  parameter  int SAMP_DIV = 64,
  parameter  int LO_TH    = FSK_LO_TH_DEF,
  parameter  int HI_TH    = FSK_HI_TH_DEF,
  parameter  int VOTE_MIN = 1,
  parameter  int MODE     = FSK_MODE_VOTE,
  localparam int NSAMP    = SYM_LEN / SAMP_DIV,
  localparam int HIT_W    = $clog2(NSAMP + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sym_sync,
  input  logic [DATA_W-1:0] cin,
  output logic              cout,
  output logic              bit_valid,
  output logic [HIT_W-1:0]  hit_cnt
);

  if (SYM_LEN % SAMP_DIV != 0) begin : g_bad_div
    $error("SYM_LEN must be a multiple of SAMP_DIV");
  end
  if (LO_TH > HI_TH) begin : g_bad_win
    $error("LO_TH must not exceed HI_TH");
  end
  if (HI_TH >= 2 ** DATA_W) begin : g_bad_hi
    $error("HI_TH must fit in DATA_W bits");
  end

  logic             w_samp_tick;
  logic             w_sym_end;
  logic             w_hit;
  logic [HIT_W-1:0] w_total;
  logic             w_dec;

  logic             r_cout;
  logic             r_bit_valid;
  logic [HIT_W-1:0] r_hit_cnt;
  logic [HIT_W-1:0] r_hits;

  fsk_sample_ticker #(
    .SYM_LEN  (SYM_LEN),
    .SAMP_DIV (SAMP_DIV)
  ) u_ticker (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_sync      (sym_sync),
    .o_samp_tick (w_samp_tick),
    .o_sym_end   (w_sym_end)
  );

  assign w_hit = w_samp_tick &&
    in_window(32'(cin), LO_TH, HI_TH);

  // last tick of a symbol lands on symbol end, so fold it in
  assign w_total = r_hits + HIT_W'(w_hit);

  always_comb begin
    w_dec = 1'b0;
    if (MODE == FSK_MODE_MAJ) begin
      w_dec = (2 * 32'(w_total)) > NSAMP;
    end else begin
      w_dec = 32'(w_total) >= VOTE_MIN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cout      <= 1'b0;
      r_bit_valid <= 1'b0;
      r_hit_cnt   <= '0;
      r_hits      <= '0;
    end else if (sym_sync) begin
      r_bit_valid <= 1'b0;
      r_hits      <= '0;
    end else if (w_sym_end) begin
      r_cout      <= w_dec;
      r_hit_cnt   <= w_total;
      r_bit_valid <= 1'b1;
      r_hits      <= '0;
    end else begin
      r_bit_valid <= 1'b0;
      if (w_samp_tick) begin
        r_hits <= w_total;
      end
    end
  end

  assign cout      = r_cout;
  assign bit_valid = r_bit_valid;
  assign hit_cnt   = r_hit_cnt;

endmodule

// File: tb/tb_fsk_demod_param.sv
// Bench for fsk_demod_param: vote and majority instances
// share stimulus; strobes are scored against queued results.
module tb_fsk_demod_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       sym_sync;
  logic [7:0] cin;

  logic       cout_v, bv_v;
  logic [2:0] hc_v;
  logic       cout_m, bv_m;
  logic [2:0] hc_m;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       b;
    logic [2:0] hc;
    int         at;
  } exp_t;

  exp_t q_v[$];
  exp_t q_m[$];

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [2:0] last_hc;

  fsk_demod_param #(
    .DATA_W(8), .SYM_LEN(256), .SAMP_DIV(64),
    .LO_TH(100), .HI_TH(200), .VOTE_MIN(1), .MODE(0)
  ) dut_v (
    .clk(clk), .rst(rst), .en(en), .sym_sync(sym_sync),
    .cin(cin), .cout(cout_v), .bit_valid(bv_v),
    .hit_cnt(hc_v)
  );

  fsk_demod_param #(
    .DATA_W(8), .SYM_LEN(256), .SAMP_DIV(64),
    .LO_TH(100), .HI_TH(200), .VOTE_MIN(1), .MODE(1)
  ) dut_m (
    .clk(clk), .rst(rst), .en(en), .sym_sync(sym_sync),
    .cin(cin), .cout(cout_m), .bit_valid(bv_m),
    .hit_cnt(hc_m)
  );

  task automatic chk(input string nm, input int got,
                     input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bv_v) begin
        if (q_v.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected vote strobe at %0d", cyc);
        end else begin
          e = q_v.pop_front();
          chk("vote cout", int'(cout_v), int'(e.b));
          chk("vote hit_cnt", int'(hc_v), int'(e.hc));
          chk("vote strobe cycle", cyc, e.at);
        end
      end
      if (bv_m) begin
        if (q_m.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected maj strobe at %0d", cyc);
        end else begin
          e = q_m.pop_front();
          chk("maj cout", int'(cout_m), int'(e.b));
          chk("maj hit_cnt", int'(hc_m), int'(e.hc));
          chk("maj strobe cycle", cyc, e.at);
        end
      end
    end
  endtask

  // s holds the four tick samples, first tick in s[7:0]
  task automatic run_sym(input logic [31:0] s,
                         input logic [2:0] hits,
                         input logic v, input logic m,
                         input int gap);
    int t0;
    t0 = cyc;
    q_v.push_back('{b: v, hc: hits, at: t0 + 256 + gap});
    q_m.push_back('{b: m, hc: hits, at: t0 + 256 + gap});
    for (int k = 1; k <= 256; k++) begin
      if (gap > 0 && k == 120) begin
        en  = 1'b0;
        cin = 8'd150;
        repeat (gap) step();
        chk("hit_cnt held while en low", int'(hc_v),
            int'(last_hc));
        en = 1'b1;
      end
      cin = (k % 64 == 0) ? s[8*(k/64-1) +: 8] : 8'd250;
      step();
    end
    last_hc = hits;
  endtask

  task automatic sync_test();
    int t0;
    for (int k = 1; k <= 100; k++) begin
      cin = (k == 64) ? 8'd150 : 8'd250;
      step();
    end
    sym_sync = 1'b1;
    cin      = 8'd150;
    step();
    sym_sync = 1'b0;
    t0 = cyc;
    q_v.push_back('{b: 1'b1, hc: 3'd1, at: t0 + 256});
    q_m.push_back('{b: 1'b0, hc: 3'd1, at: t0 + 256});
    for (int k = 1; k <= 256; k++) begin
      cin = (k == 256) ? 8'd150 : 8'd250;
      step();
    end
    last_hc = 3'd1;
  endtask

  task automatic reset_test();
    for (int k = 1; k <= 100; k++) begin
      cin = (k == 64) ? 8'd150 : 8'd250;
      step();
    end
    rst = 1'b1;
    step();
    chk("rst mid cout", int'(cout_v), 0);
    chk("rst mid hit_cnt vote", int'(hc_v), 0);
    chk("rst mid hit_cnt maj", int'(hc_m), 0);
    chk("rst mid bit_valid", int'(bv_v), 0);
    rst     = 1'b0;
    last_hc = 3'd0;
    run_sym({8'd150, 8'd250, 8'd250, 8'd250},
            3'd1, 1'b1, 1'b0, 0);
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b1;
    sym_sync = 1'b0;
    cin      = 8'd0;
    last_hc  = 3'd0;
    fork
      monitor();
    join_none
    repeat (3) step();
    chk("reset cout vote", int'(cout_v), 0);
    chk("reset cout maj", int'(cout_m), 0);
    chk("reset hit_cnt vote", int'(hc_v), 0);
    chk("reset hit_cnt maj", int'(hc_m), 0);
    chk("reset bit_valid vote", int'(bv_v), 0);
    chk("reset bit_valid maj", int'(bv_m), 0);
    rst = 1'b0;

    run_sym({8'd150, 8'd150, 8'd150, 8'd150},
            3'd4, 1'b1, 1'b1, 0);
    run_sym({8'd50, 8'd50, 8'd50, 8'd50},
            3'd0, 1'b0, 1'b0, 0);
    run_sym({8'd200, 8'd100, 8'd200, 8'd100},
            3'd4, 1'b1, 1'b1, 0);
    run_sym({8'd250, 8'd150, 8'd250, 8'd250},
            3'd1, 1'b1, 1'b0, 0);
    run_sym({8'd150, 8'd250, 8'd150, 8'd150},
            3'd3, 1'b1, 1'b1, 0);
    run_sym({8'd250, 8'd100, 8'd201, 8'd99},
            3'd1, 1'b1, 1'b0, 0);
    run_sym({8'd50, 8'd50, 8'd150, 8'd150},
            3'd2, 1'b1, 1'b0, 0);
    run_sym({8'd250, 8'd250, 8'd250, 8'd250},
            3'd0, 1'b0, 1'b0, 50);

    sync_test();
    reset_test();

    repeat (5) step();
    chk("pending vote strobes", q_v.size(), 0);
    chk("pending maj strobes", q_m.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
